// File: rtl/elevator_scheduler.sv
// SCAN (collective) scheduler for a four-floor car: latches calls, picks direction,
// sequences hoist motor and door from the floor sensor alone.
module elevator_scheduler #(
  parameter int DOOR_CYCLES = 8,
  parameter int N_FLOORS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          current_floor,
  input  logic [N_FLOORS-1:0] buttons_in,
  input  logic [N_FLOORS-1:0] buttons_out,
  output logic [N_FLOORS-1:0] pending,
  output logic                motor_up,
  output logic                motor_down,
  output logic                door_open,
  output logic                dir_up,
  output logic                dir_down,
  output logic                arrive
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_t;

  localparam logic [7:0] TLOAD = 8'(DOOR_CYCLES - 1);

  state_t              r_state, w_next;
  logic                r_pref, w_pref_next;
  logic [7:0]          r_timer;
  logic [N_FLOORS-1:0] r_pending;
  logic                r_arrive;

  logic [N_FLOORS-1:0] w_req, w_onehot, w_clr;
  logic                w_here, w_above, w_below, w_press_here;

  assign w_req        = buttons_in | buttons_out;
  assign w_here       = r_pending[current_floor];
  assign w_press_here = w_req[current_floor];

  always_comb begin
    w_above  = 1'b0;
    w_below  = 1'b0;
    w_onehot = '0;
    w_onehot[current_floor] = 1'b1;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(current_floor)) w_above = w_above | r_pending[i];
      if (i < int'(current_floor)) w_below = w_below | r_pending[i];
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pref_next = r_pref;
    case (r_state)
      S_IDLE: begin
        if (w_here)       w_next = S_DOOR;
        else if (w_above) begin w_next = S_UP;   w_pref_next = 1'b1; end
        else if (w_below) begin w_next = S_DOWN; w_pref_next = 1'b0; end
      end
      S_UP: begin
        if (w_here)        w_next = S_DOOR;
        else if (!w_above) w_next = S_IDLE;
      end
      S_DOWN: begin
        if (w_here)        w_next = S_DOOR;
        else if (!w_below) w_next = S_IDLE;
      end
      S_DOOR: begin
        // A press at this floor holds the door, so leave only on an undisturbed expiry
        if (r_timer == 8'd0 && !w_press_here) begin
          if (r_pref) begin
            if (w_above)      w_next = S_UP;
            else if (w_below) begin w_next = S_DOWN; w_pref_next = 1'b0; end
            else              w_next = S_IDLE;
          end else begin
            if (w_below)      w_next = S_DOWN;
            else if (w_above) begin w_next = S_UP; w_pref_next = 1'b1; end
            else              w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_clr = (w_next == S_DOOR || r_state == S_DOOR) ? w_onehot : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pref    <= 1'b1;
      r_pending <= '0;
      r_timer   <= 8'd0;
      r_arrive  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pref    <= w_pref_next;
      r_pending <= (r_pending | w_req) & ~w_clr;
      r_arrive  <= (w_next == S_DOOR) && (r_state != S_DOOR);
      if (w_next == S_DOOR && (r_state != S_DOOR || w_press_here))
        r_timer <= TLOAD;
      else if (r_state == S_DOOR && r_timer != 8'd0)
        r_timer <= r_timer - 8'd1;
    end
  end

  assign pending    = r_pending;
  assign motor_up   = (r_state == S_UP);
  assign motor_down = (r_state == S_DOWN);
  assign door_open  = (r_state == S_DOOR);
  assign dir_up     = (r_state == S_UP)   || (r_state == S_DOOR && r_pref);
  assign dir_down   = (r_state == S_DOWN) || (r_state == S_DOOR && !r_pref);
  assign arrive     = r_arrive;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: floor sensor driven by hand, expected
// output words {motor_up,motor_down,door_open,dir_up,dir_down,arrive} precomputed.
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] current_floor;
  logic [3:0] buttons_in, buttons_out;
  logic [3:0] pending;
  logic       motor_up, motor_down, door_open, dir_up, dir_down, arrive;
  logic [5:0] w_out;

  int n_chk = 0;
  int n_fail = 0;
  int n_arr = 0;
  int a0;
  bit mon_en = 1'b0;

  elevator_scheduler #(.DOOR_CYCLES(8), .N_FLOORS(4)) dut (
    .clk(clk), .reset(reset), .current_floor(current_floor),
    .buttons_in(buttons_in), .buttons_out(buttons_out), .pending(pending),
    .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
    .dir_up(dir_up), .dir_down(dir_down), .arrive(arrive)
  );

  always #5 clk = ~clk;

  assign w_out = {motor_up, motor_down, door_open, dir_up, dir_down, arrive};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Door already open for its first cycle; expect 7 more open cycles then `after`
  task automatic run_door(input string tag, input logic [5:0] after);
    step(7);
    chk({tag, "_door_last"}, 32'(door_open), 32'd1);
    step(1);
    chk({tag, "_after"}, 32'(w_out), 32'(after));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (arrive) n_arr++;
      chk("excl", 32'((motor_up & motor_down) | ((motor_up | motor_down) & door_open)), 32'd0);
    end
  end

  initial begin
    reset = 1'b0; current_floor = 2'd0; buttons_in = 4'd0; buttons_out = 4'd0;
    step(2);
    chk("rst_out", 32'(w_out), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    step(1);

    // Hall call at floor 3 from floor 0
    buttons_out = 4'b1000;
    step(1);
    buttons_out = 4'b0000;
    chk("t1_pend", 32'(pending), 32'h8);
    chk("t1_idle", 32'(w_out), 32'd0);
    step(1);
    chk("t1_up", 32'(w_out), 32'(6'b100100));
    current_floor = 2'd1; step(1);
    chk("t1_f1", 32'(w_out), 32'(6'b100100));
    current_floor = 2'd2; step(1);
    chk("t1_f2", 32'(w_out), 32'(6'b100100));
    current_floor = 2'd3; step(1);
    chk("t1_stop", 32'(w_out), 32'(6'b001101));
    chk("t1_clr", 32'(pending), 32'h0);
    step(1);
    chk("t1_door2", 32'(w_out), 32'(6'b001100));
    step(6);
    chk("t1_door8", 32'(door_open), 32'd1);
    step(1);
    chk("t1_idle_end", 32'(w_out), 32'd0);

    // Car calls 1 and 2 from floor 3
    buttons_in = 4'b0110;
    step(1);
    buttons_in = 4'b0000;
    chk("t2_pend", 32'(pending), 32'h6);
    step(1);
    chk("t2_down", 32'(w_out), 32'(6'b010010));
    current_floor = 2'd2; step(1);
    chk("t2_stop2", 32'(w_out), 32'(6'b001011));
    chk("t2_pend2", 32'(pending), 32'h2);
    run_door("t2_d2", 6'b010010);
    current_floor = 2'd1; step(1);
    chk("t2_stop1", 32'(w_out), 32'(6'b001011));
    chk("t2_pend1", 32'(pending), 32'h0);
    run_door("t2_d1", 6'b000000);

    // SCAN reversal: moving up from 1 toward 3, floor 0 called meanwhile
    buttons_out = 4'b1000;
    step(1);
    buttons_out = 4'b0000;
    step(1);
    chk("t3_up", 32'(w_out), 32'(6'b100100));
    buttons_out = 4'b0001;
    step(1);
    buttons_out = 4'b0000;
    chk("t3_pend", 32'(pending), 32'h9);
    chk("t3_still_up", 32'(w_out), 32'(6'b100100));
    current_floor = 2'd2; step(1);
    current_floor = 2'd3; step(1);
    chk("t3_stop3", 32'(w_out), 32'(6'b001101));
    chk("t3_pend3", 32'(pending), 32'h1);
    run_door("t3_d3", 6'b010010);
    current_floor = 2'd2; step(1);
    chk("t3_pass2", 32'(w_out), 32'(6'b010010));
    current_floor = 2'd1; step(1);
    current_floor = 2'd0; step(1);
    chk("t3_stop0", 32'(w_out), 32'(6'b001011));
    chk("t3_pend0", 32'(pending), 32'h0);
    run_door("t3_d0", 6'b000000);

    // Door hold at floor 2
    a0 = n_arr;
    buttons_in = 4'b0100;
    step(1);
    buttons_in = 4'b0000;
    step(1);
    chk("t4_up", 32'(w_out), 32'(6'b100100));
    current_floor = 2'd1; step(1);
    current_floor = 2'd2; step(1);
    chk("t4_stop", 32'(w_out), 32'(6'b001101));
    step(2);
    buttons_out = 4'b0100;
    step(5);
    buttons_out = 4'b0000;
    chk("t4_hold", 32'(w_out), 32'(6'b001100));
    chk("t4_pend", 32'(pending), 32'h0);
    run_door("t4_d2", 6'b000000);
    chk("t4_arrives", 32'(n_arr - a0), 32'd1);

    // Simultaneous above/below from floor 1: up wins
    current_floor = 2'd1; step(1);
    buttons_in = 4'b1001;
    step(1);
    buttons_in = 4'b0000;
    chk("t5_pend", 32'(pending), 32'h9);
    step(1);
    chk("t5_up", 32'(w_out), 32'(6'b100100));
    current_floor = 2'd2; step(1);
    current_floor = 2'd3; step(1);
    chk("t5_stop3", 32'(w_out), 32'(6'b001101));
    run_door("t5_d3", 6'b010010);
    current_floor = 2'd2; step(1);
    current_floor = 2'd1; step(1);
    current_floor = 2'd0; step(1);
    chk("t5_stop0", 32'(w_out), 32'(6'b001011));
    run_door("t5_d0", 6'b000000);

    // Reset mid-move
    buttons_out = 4'b1000;
    step(1);
    buttons_out = 4'b0000;
    step(1);
    chk("t6_up", 32'(w_out), 32'(6'b100100));
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("t6_rst_out", 32'(w_out), 32'd0);
    chk("t6_rst_pend", 32'(pending), 32'h0);
    step(3);
    chk("t6_quiet", 32'(w_out), 32'd0);
    chk("t6_quiet_pend", 32'(pending), 32'h0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
